// File: rtl/sap_pkg.sv
// sap_pkg -- shared definitions for the SAP-1 run/load controller slice.
//   Provides the run-controller state encoding (also driven out on the
//   debug/LED "state" port), default RAM geometry, and the SAP-1 control
//   word bit positions shared with controlunit and the datapath.
package sap_pkg;

   localparam int unsigned SAP_ADDR_W = 4;
   localparam int unsigned SAP_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_HALT  = 3'd4
   } run_state_e;

   // SAP-1 control word bit positions (controlunit cword, MSB first).
   localparam int unsigned CW_HLT = 15;
   localparam int unsigned CW_MI  = 14;
   localparam int unsigned CW_RI  = 13;
   localparam int unsigned CW_RO  = 12;
   localparam int unsigned CW_IO  = 11;
   localparam int unsigned CW_II  = 10;
   localparam int unsigned CW_AI  = 9;
   localparam int unsigned CW_AO  = 8;
   localparam int unsigned CW_EO  = 7;
   localparam int unsigned CW_SU  = 6;
   localparam int unsigned CW_BI  = 5;
   localparam int unsigned CW_OI  = 4;
   localparam int unsigned CW_CE  = 3;
   localparam int unsigned CW_CO  = 2;
   localparam int unsigned CW_J   = 1;
   localparam int unsigned CW_FI  = 0;

endpackage

// File: rtl/sap_clken_div.sv
// sap_clken_div -- CPU clock-enable divider for RUN mode.
//   restart : the next cycle is the first cycle of a run (count restarts at 0)
//   run     : the next cycle continues an ongoing run
//   pulse   : the next cycle is cycle CLK_DIV-1 (mod CLK_DIV) of the run;
//             the caller registers it into cpu_clken
module sap_clken_div #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic sysclk,
   input  logic clear_n,
   input  logic restart,
   input  logic run,
   output logic pulse
);

   localparam int unsigned       CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;

   // cnt_q is the run-cycle index (mod CLK_DIV) of the current cycle;
   // cnt_next is the index of the upcoming cycle, so the pulse can be
   // registered and still land on that cycle.
   always_comb begin
      cnt_next = '0;
      if (!restart && (cnt_q != CNT_LAST)) begin
         cnt_next = cnt_q + 1'b1;
      end
      cnt_d = cnt_q;
      if (restart || run) begin
         cnt_d = cnt_next;
      end
      pulse = (restart || run) && (cnt_next == CNT_LAST);
   end

   always_ff @(posedge sysclk or negedge clear_n) begin
      if (!clear_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sap_run_controller.sv
// sap_run_controller -- SAP-1 run/load sequencer.
//   Shares the program RAM between an external byte loader and the CPU and
//   drives controlunit's clear and clock enable.
//   Inputs : sysclk, clear_n (async active-low), ld_start, ld_valid, ld_data,
//            run_req, step_req, cpu_reset_req, cpu_halt
//   Outputs: ld_ready, ram_we/ram_addr/ram_wdata (loader write port),
//            ram_sel_loader (RAM mux select), cpu_clear, cpu_clken,
//            state (debug), load_count (bytes accepted in current/last load)
//   All outputs are registered.
module sap_run_controller
   import sap_pkg::*;
#(
   parameter int unsigned ADDR_W  = SAP_ADDR_W,
   parameter int unsigned DATA_W  = SAP_DATA_W,
   parameter int unsigned CLK_DIV = 1
) (
   input  logic              sysclk,
   input  logic              clear_n,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              run_req,
   input  logic              step_req,
   input  logic              cpu_reset_req,
   input  logic              cpu_halt,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_sel_loader,
   output logic              cpu_clear,
   output logic              cpu_clken,
   output logic [2:0]        state,
   output logic [ADDR_W:0]   load_count
);

   localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'((1 << ADDR_W) - 1);

   run_state_e        state_q, state_d;
   logic              ld_ready_q, ld_ready_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_sel_q, ram_sel_d;
   logic              cpu_clear_q, cpu_clear_d;
   logic              cpu_clken_q, cpu_clken_d;
   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic              step_q;

   logic step_edge;
   logic accept;
   logic go_load;
   logic step_pulse_d;
   logic div_restart, div_run, div_pulse;

   assign step_edge = step_req & ~step_q;
   assign accept    = (state_q == ST_LOAD) & ld_valid & ld_ready_q;
   assign go_load   = ld_start & ((state_q == ST_IDLE) | (state_q == ST_PAUSE) |
                                  (state_q == ST_HALT));

   always_comb begin
      state_d      = state_q;
      ld_ready_d   = 1'b0;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_sel_d    = 1'b0;
      cpu_clear_d  = 1'b0;
      step_pulse_d = 1'b0;
      load_count_d = load_count_q;

      unique case (state_q)
         ST_IDLE: begin
            cpu_clear_d = 1'b1;
            if (!cpu_reset_req) begin
               if (run_req) begin
                  state_d     = ST_RUN;
                  cpu_clear_d = 1'b0;
               end else if (step_edge) begin
                  state_d      = ST_PAUSE;
                  cpu_clear_d  = 1'b0;
                  step_pulse_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            ram_sel_d   = 1'b1;
            cpu_clear_d = 1'b1;
            ld_ready_d  = 1'b1;
            if (accept) begin
               ram_we_d     = 1'b1;
               ram_addr_d   = load_count_q[ADDR_W-1:0];
               ram_wdata_d  = ld_data;
               load_count_d = load_count_q + 1'b1;
               // Final byte: leave LOAD but keep the loader owning the RAM
               // until this last write has gone out.
               if (load_count_q == LAST_COUNT) begin
                  ld_ready_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end
         ST_RUN: begin
            if (cpu_halt) begin
               state_d = ST_HALT;
            end else if (!run_req) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (cpu_reset_req) begin
               state_d     = ST_IDLE;
               cpu_clear_d = 1'b1;
            end else if (cpu_halt) begin
               state_d = ST_HALT;
            end else if (run_req) begin
               state_d = ST_RUN;
            end else if (step_edge) begin
               step_pulse_d = 1'b1;
            end
         end
         ST_HALT: begin
            if (cpu_reset_req) begin
               state_d     = ST_IDLE;
               cpu_clear_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cpu_clear_d = 1'b1;
         end
      endcase

      // A load request overrides every other decision in IDLE/PAUSE/HALT.
      if (go_load) begin
         state_d      = ST_LOAD;
         ld_ready_d   = 1'b1;
         ram_sel_d    = 1'b1;
         cpu_clear_d  = 1'b1;
         step_pulse_d = 1'b0;
         load_count_d = '0;
      end
   end

   assign div_restart = (state_d == ST_RUN) && (state_q != ST_RUN);
   assign div_run     = (state_d == ST_RUN) && (state_q == ST_RUN);

   sap_clken_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clken_div (
      .sysclk  (sysclk),
      .clear_n (clear_n),
      .restart (div_restart),
      .run     (div_run),
      .pulse   (div_pulse)
   );

   // div_pulse is only ever set when the next state is RUN, so a halt in
   // RUN naturally drops the pending pulse.
   assign cpu_clken_d = div_pulse | step_pulse_d;

   always_ff @(posedge sysclk or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= ST_IDLE;
         ld_ready_q   <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_sel_q    <= 1'b0;
         cpu_clear_q  <= 1'b1;
         cpu_clken_q  <= 1'b0;
         load_count_q <= '0;
         step_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ld_ready_q   <= ld_ready_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_sel_q    <= ram_sel_d;
         cpu_clear_q  <= cpu_clear_d;
         cpu_clken_q  <= cpu_clken_d;
         load_count_q <= load_count_d;
         step_q       <= step_req;
      end
   end

   assign state          = state_q;
   assign ld_ready       = ld_ready_q;
   assign ram_we         = ram_we_q;
   assign ram_addr       = ram_addr_q;
   assign ram_wdata      = ram_wdata_q;
   assign ram_sel_loader = ram_sel_q;
   assign cpu_clear      = cpu_clear_q;
   assign cpu_clken      = cpu_clken_q;
   assign load_count     = load_count_q;

endmodule

// File: tb/tb_sap_run_controller.sv
// tb_sap_run_controller -- self-checking bench for sap_run_controller
// (ADDR_W=4, DATA_W=8, CLK_DIV=3) against a mode-level reference model.
module tb_sap_run_controller;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DIV    = 3;
   localparam int NBYTES = 16;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_PAUSE = 3;
   localparam int M_HALT  = 4;

   logic              sysclk        = 1'b0;
   logic              clear_n       = 1'b1;
   logic              ld_start      = 1'b0;
   logic              ld_valid      = 1'b0;
   logic [DATA_W-1:0] ld_data       = '0;
   logic              run_req       = 1'b0;
   logic              step_req      = 1'b0;
   logic              cpu_reset_req = 1'b0;
   logic              cpu_halt      = 1'b0;
   logic              ld_ready;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_sel_loader;
   logic              cpu_clear;
   logic              cpu_clken;
   logic [2:0]        state;
   logic [ADDR_W:0]   load_count;

   sap_run_controller #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .CLK_DIV (DIV)
   ) dut (
      .sysclk         (sysclk),
      .clear_n        (clear_n),
      .ld_start       (ld_start),
      .ld_valid       (ld_valid),
      .ld_data        (ld_data),
      .ld_ready       (ld_ready),
      .run_req        (run_req),
      .step_req       (step_req),
      .cpu_reset_req  (cpu_reset_req),
      .cpu_halt       (cpu_halt),
      .ram_we         (ram_we),
      .ram_addr       (ram_addr),
      .ram_wdata      (ram_wdata),
      .ram_sel_loader (ram_sel_loader),
      .cpu_clear      (cpu_clear),
      .cpu_clken      (cpu_clken),
      .state          (state),
      .load_count     (load_count)
   );

   always #5 sysclk = ~sysclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: operating mode plus a few counters; every output is
   // derived from these.
   int   m_mode, m_count, m_run_idx, m_addr, m_wdata;
   bit   m_we, m_pulse, m_clken, m_step_prev;
   logic [7:0] exp_ram [NBYTES];
   logic [7:0] shadow  [NBYTES];
   int   wr_count;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_count = 0; m_run_idx = 0; m_addr = 0; m_wdata = 0;
      m_we = 0; m_pulse = 0; m_clken = 0; m_step_prev = 0;
   endtask

   task automatic model_edge();
      bit edge_s;
      if (!clear_n) begin
         model_reset();
         return;
      end
      edge_s  = step_req && !m_step_prev;
      m_we    = 0;
      m_pulse = 0;
      if (ld_start && (m_mode == M_IDLE || m_mode == M_PAUSE || m_mode == M_HALT)) begin
         m_mode  = M_LOAD;
         m_count = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (!cpu_reset_req) begin
               if (run_req) begin m_mode = M_RUN; m_run_idx = 0; end
               else if (edge_s) begin m_mode = M_PAUSE; m_pulse = 1; end
            end
            M_LOAD: if (ld_valid) begin
               m_we = 1; m_addr = m_count; m_wdata = int'(ld_data);
               exp_ram[m_count] = ld_data;
               m_count++;
               if (m_count == NBYTES) m_mode = M_IDLE;
            end
            M_RUN: begin
               if (cpu_halt) m_mode = M_HALT;
               else if (!run_req) m_mode = M_PAUSE;
               else m_run_idx++;
            end
            M_PAUSE: begin
               if (cpu_reset_req) m_mode = M_IDLE;
               else if (cpu_halt) m_mode = M_HALT;
               else if (run_req) begin m_mode = M_RUN; m_run_idx = 0; end
               else if (edge_s) m_pulse = 1;
            end
            M_HALT: if (cpu_reset_req) m_mode = M_IDLE;
            default: ;
         endcase
      end
      m_step_prev = step_req;
      m_clken = m_pulse || (m_mode == M_RUN && (m_run_idx % DIV) == DIV - 1);
   endtask

   task automatic compare_outputs();
      check_eq("state", 32'(state), 32'(m_mode));
      check_eq("ld_ready", 32'(ld_ready), 32'(m_mode == M_LOAD));
      check_eq("ram_we", 32'(ram_we), 32'(m_we));
      check_eq("ram_sel_loader", 32'(ram_sel_loader), 32'(m_mode == M_LOAD || m_we));
      check_eq("cpu_clear", 32'(cpu_clear), 32'(m_mode == M_IDLE || m_mode == M_LOAD));
      check_eq("cpu_clken", 32'(cpu_clken), 32'(m_clken));
      check_eq("load_count", 32'(load_count), 32'(m_count));
      if (m_we) begin
         check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
         check_eq("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
      end
      if (ram_we === 1'b1) begin
         shadow[ram_addr] = ram_wdata;
         wr_count++;
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      model_edge();
      @(negedge sysclk);
      compare_outputs();
   endtask

   task automatic check_reset_values();
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
      check_eq("rst_ram_we", 32'(ram_we), 32'd0);
      check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
      check_eq("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      check_eq("rst_sel", 32'(ram_sel_loader), 32'd0);
      check_eq("rst_cpu_clear", 32'(cpu_clear), 32'd1);
      check_eq("rst_cpu_clken", 32'(cpu_clken), 32'd0);
      check_eq("rst_load_count", 32'(load_count), 32'd0);
   endtask

   // Feed bytes while the model is in LOAD; gap = idle cycles after each byte,
   // base < 0 selects random data.
   task automatic load_bytes(input int gap, input int base);
      int i = 0;
      int guard = 0;
      while (m_mode == M_LOAD && guard < 400) begin
         ld_valid = 1'b1;
         ld_data  = (base >= 0) ? 8'(base + i) : 8'($urandom);
         tick();
         i++; guard++;
         ld_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            if (m_mode != M_LOAD) break;
            tick();
            guard++;
         end
      end
      ld_valid = 1'b0;
   endtask

   task automatic check_image(input string tag);
      for (int i = 0; i < NBYTES; i++) check_eq(tag, 32'(shadow[i]), 32'(exp_ram[i]));
      check_eq({tag, "_writes"}, 32'(wr_count), 32'(NBYTES));
   endtask

   initial begin
      int pulses;
      model_reset();
      #1 clear_n = 1'b0;
      #2 check_reset_values();
      @(negedge sysclk);
      clear_n = 1'b1;
      repeat (2) tick();

      // Back-to-back load of 0x10..0x1F.
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      wr_count = 0;
      load_bytes(0, 'h10);
      tick();
      for (int i = 0; i < NBYTES; i++) check_eq("seq_img", 32'(shadow[i]), 32'(8'h10 + i));
      check_eq("seq_writes", 32'(wr_count), 32'(NBYTES));
      check_eq("seq_count", 32'(load_count), 32'd16);
      check_eq("seq_state", 32'(state), 32'd0);
      check_eq("seq_ready", 32'(ld_ready), 32'd0);
      check_eq("seq_sel", 32'(ram_sel_loader), 32'd0);

      // Stalled loader: 3-cycle gaps between bytes.
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      wr_count = 0;
      load_bytes(3, -1);
      tick();
      check_image("gap_img");

      // Free run at CLK_DIV=3, then halt.
      run_req = 1'b1; tick();
      pulses = 0;
      repeat (12) begin tick(); if (cpu_clken === 1'b1) pulses++; end
      check_eq("run_pulses", 32'(pulses), 32'd4);
      cpu_halt = 1'b1; tick();
      pulses = 0;
      repeat (6) begin tick(); if (cpu_clken === 1'b1) pulses++; end
      check_eq("halt_pulses", 32'(pulses), 32'd0);
      check_eq("halt_state", 32'(state), 32'd4);
      cpu_halt = 1'b0; run_req = 1'b0;

      // Pause and single-step.
      cpu_reset_req = 1'b1; tick(); cpu_reset_req = 1'b0;
      run_req = 1'b1; repeat (4) tick();
      run_req = 1'b0; tick();
      step_req = 1'b1;
      pulses = 0;
      repeat (10) begin tick(); if (cpu_clken === 1'b1) pulses++; end
      check_eq("step_held", 32'(pulses), 32'd1);
      step_req = 1'b0; tick();
      step_req = 1'b1;
      pulses = 0;
      repeat (3) begin tick(); if (cpu_clken === 1'b1) pulses++; end
      check_eq("step_second", 32'(pulses), 32'd1);
      step_req = 1'b0; tick();

      // HALT with ld_start and cpu_reset_req together: load wins.
      run_req = 1'b1; cpu_halt = 1'b1; repeat (2) tick();
      run_req = 1'b0;
      check_eq("halt2_state", 32'(state), 32'd4);
      ld_start = 1'b1; cpu_reset_req = 1'b1; tick();
      ld_start = 1'b0; cpu_reset_req = 1'b0; cpu_halt = 1'b0;
      check_eq("hl_state", 32'(state), 32'd1);
      check_eq("hl_clear", 32'(cpu_clear), 32'd1);
      check_eq("hl_sel", 32'(ram_sel_loader), 32'd1);
      wr_count = 0;
      load_bytes(0, -1);
      tick();
      check_image("hl_img");

      // Random traffic against the model.
      for (int c = 0; c < 800; c++) begin
         ld_start      = ($urandom_range(39) == 0);
         ld_valid      = $urandom_range(1);
         ld_data       = 8'($urandom);
         cpu_reset_req = ($urandom_range(29) == 0);
         cpu_halt      = ($urandom_range(19) == 0);
         if ($urandom_range(7) == 0) run_req = ~run_req;
         if ($urandom_range(2) == 0) step_req = ~step_req;
         tick();
      end
      ld_start = 1'b0; ld_valid = 1'b0; cpu_halt = 1'b0; run_req = 1'b0; step_req = 1'b0;
      cpu_reset_req = 1'b0;
      if (m_mode == M_LOAD) load_bytes(0, -1);
      cpu_reset_req = 1'b1; repeat (2) tick(); cpu_reset_req = 1'b0;

      // Asynchronous reset in the middle of a load.
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      ld_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin ld_data = 8'($urandom); tick(); end
      check_eq("mid_count", 32'(load_count), 32'd5);
      #2 clear_n = 1'b0;
      #1 check_reset_values();
      model_reset();
      ld_valid = 1'b0;
      repeat (2) tick();
      clear_n = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
